bytestream_dut_arbiter: RTL

- Round-robin scheduler that shares the single 16-bit Avalon-ST input of the bytestream DUT between NUM_IN upstream requesters.
- Sits in front of the DUT-side timing adapter.
- Grants one requester at a time for a bounded burst of beats, then rotates to the next.
- Provides a one-deep registered output stage with full ready/valid backpressure toward the requesters.

---
 rtl/bytestream_pkg.sv | 22 ++
 rtl/rr_select.sv | 26 ++
 rtl/bytestream_dut_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bytestream_pkg.sv
// Shared constants, FSM state type and width helper for the bytestream
// input arbiter and its round-robin picker.
package bytestream_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of one bit, so single-value ranges still get a signal.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request after 'last',
// searching upward with wrap-around.
module rr_select
    import bytestream_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int IDX_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  sel,
    output logic              any_req
);

    // Walk the search order backwards so the earliest candidate is written last.
    always_comb begin
        sel     = '0;
        any_req = |req;
        for (int k = NUM_IN; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_IN]) begin
                sel = IDX_W'((int'(last) + k) % NUM_IN);
            end
        end
    end

endmodule

// File: rtl/bytestream_dut_arbiter.sv
// Round-robin burst arbiter sharing the bytestream DUT input between NUM_IN
// requesters, with a one-deep registered output stage and full backpressure.
module bytestream_dut_arbiter
    import bytestream_pkg::*;
#(
    parameter int NUM_IN    = 2,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [NUM_IN-1:0]        grant
);

    localparam int                IDX_W    = clog2(NUM_IN);
    localparam int                CNT_W    = clog2(BURST_MAX + 1);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  sel;
    logic              any_req;
    logic [CNT_W-1:0]  beat_cnt;
    logic              g_valid;
    logic              g_ready;
    logic              xfer;
    logic              burst_done;
    logic [DATA_W-1:0] g_data;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    rr_select #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_select (
        .req     (in_valid),
        .last    (last_grant),
        .sel     (sel),
        .any_req (any_req)
    );

    // Stage p0: granted requester handshake and FSM decode. While granted,
    // last_grant is the index of the current owner.
    always_comb begin
        g_valid    = in_valid[last_grant];
        g_data     = in_data[int'(last_grant) * DATA_W +: DATA_W];
        g_ready    = (state == GRANT) && (!vld_p1 || out_ready);
        xfer       = g_ready && g_valid;
        burst_done = (xfer && (beat_cnt == CNT_LAST)) || (g_ready && !g_valid);

        in_ready             = '0;
        in_ready[last_grant] = g_ready;

        state_nxt = state;
        case (state)
            IDLE:    if (any_req)    state_nxt = GRANT;
            GRANT:   if (burst_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LAST_RST;
            beat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (any_req) begin
                    grant      <= NUM_IN'(1) << sel;
                    last_grant <= sel;
                    beat_cnt   <= '0;
                end
            end else if (burst_done) begin
                // A stalled owner never reaches here: burst_done needs g_ready.
                grant    <= '0;
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Stage p1: one-deep output register; a new beat may replace a draining one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= g_data;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(grant))
                else $error("grant not one-hot-or-zero: %b", grant);
            assert ($onehot0(in_ready))
                else $error("more than one in_ready high: %b", in_ready);
        end
    end
`endif

endmodule
